// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/gnt/rvalid, decode valid/ready (optional FETCH_MISALIGN_TRAP_EN)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] instret
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;
`endif

    state_t      state_q;
    logic        req_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [31:0] instret_q;
    logic [31:0] next_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_q;
    logic        target_bad_d;
`endif

    // Next fetch address on retire; target low bits are dropped so fetches stay word aligned
    always_comb begin
        next_pc_d = pc_src ? (pc_target & 32'hFFFF_FFFC) : pc_plus4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        target_bad_d = pc_src && (pc_target[1:0] != 2'b00);
`endif
    end

    // Fetch FSM; req_q is held low for the first cycle out of reset so imem_req is purely registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            valid_q    <= 1'b0;
            instret_q  <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_q && imem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q    <= imem_rdata;
                        pc_q       <= fetch_pc_q;
                        pc_plus4_q <= fetch_pc_q + 32'd4;
                        valid_q    <= 1'b1;
                        state_q    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        valid_q   <= 1'b0;
                        instr_q   <= NOP_INSTR;
                        instret_q <= instret_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (target_bad_d) begin
                            misaligned_q <= 1'b1;
                            state_q      <= S_HALT;
                        end else begin
                            fetch_pc_q <= next_pc_d;
                            req_q      <= 1'b1;
                            state_q    <= S_REQ;
                        end
`else
                        fetch_pc_q <= next_pc_d;
                        req_q      <= 1'b1;
                        state_q    <= S_REQ;
`endif
                    end
                end
                default: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    // S_HALT is terminal until reset
                    req_q <= 1'b0;
`else
                    state_q <= S_REQ;
                    req_q   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign instret     = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, corner sequences, randomized model
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [31:0] instret;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int tests    = 0;
    int failures = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .instret     (instret)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        src;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
    endtask

    task automatic row(input int i, input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic src, input logic [31:0] tgt,
                       input logic ereq, input logic [31:0] eaddr, input logic ev,
                       input logic [31:0] einstr, input logic [31:0] epc, input logic [31:0] ecnt);
        tbl[i] = '{g, rv, rd, rdy, src, tgt, ereq, eaddr, ev, einstr, epc, ecnt};
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pc4"}, pc_plus4, 32'h4);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    // Zero-wait fetch of one word at exp_addr; leaves the instruction presented to decode
    task automatic do_fetch(input string tag, input logic [31:0] data, input logic [31:0] exp_addr);
        for (int k = 0; k < 10 && !imem_req; k++) tick();
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, exp_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_pc"}, pc, exp_addr);
        chk({tag, "_pc4"}, pc_plus4, exp_addr + 32'd4);
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        instr_ready = 1'b1;
        pc_src      = src;
        pc_target   = tgt;
        tick();
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m_have;
        logic        busy;
        logic        real_rv;
        int          rv_wait;
        int          retires;
        logic [31:0] m_fetch, m_instr, m_pc, m_cnt, busy_addr;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_reset_state("reset");

        //          i  gnt rv rdata          rdy src tgt     | req addr    v  instr          pc      cnt
        row( 0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  0);
        row( 1, 1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h0,  0, NOP,           32'h0,  0);
        row( 2, 1, 1, 32'h0050_0093,  0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  0);
        row( 3, 1, 0, 32'h0,          1, 0, 32'h0,    0, 32'h0,  1, 32'h0050_0093, 32'h0,  0);
        row( 4, 1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h4,  0, NOP,           32'h0,  1);
        row( 5, 1, 1, 32'h0010_0113,  0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  1);
        row( 6, 1, 0, 32'h0,          1, 0, 32'h0,    0, 32'h0,  1, 32'h0010_0113, 32'h4,  1);
        row( 7, 1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h8,  0, NOP,           32'h0,  2);
        row( 8, 1, 1, 32'h0020_0193,  0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  2);
        row( 9, 0, 0, 32'h0,          0, 1, 32'h80,   0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(10, 0, 1, 32'hDEAD_BEEF,  0, 1, 32'h80,   0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(11, 0, 0, 32'h0,          0, 0, 32'h0,    0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(12, 0, 1, 32'hCAFE_F00D,  0, 1, 32'h100,  0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(13, 0, 0, 32'h0,          0, 0, 32'h0,    0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(14, 0, 0, 32'h0,          1, 1, 32'h40,   0, 32'h0,  1, 32'h0020_0193, 32'h8,  2);
        row(15, 0, 0, 32'h0,          0, 0, 32'h0,    1, 32'h40, 0, NOP,           32'h0,  3);
        row(16, 0, 1, 32'h1234_5678,  0, 0, 32'h0,    1, 32'h40, 0, NOP,           32'h0,  3);
        row(17, 1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h40, 0, NOP,           32'h0,  3);
        row(18, 0, 0, 32'h0,          0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  3);
        row(19, 0, 1, 32'h0030_0213,  0, 0, 32'h0,    0, 32'h0,  0, NOP,           32'h0,  3);
        row(20, 0, 0, 32'h0,          1, 0, 32'h0,    0, 32'h0,  1, 32'h0030_0213, 32'h40, 3);
        row(21, 1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h44, 0, NOP,           32'h0,  4);

        reset = 1'b0;
        for (int i = 0; i < 22; i++) begin
            imem_gnt    = tbl[i].gnt;
            imem_rvalid = tbl[i].rv;
            imem_rdata  = tbl[i].rdata;
            instr_ready = tbl[i].rdy;
            pc_src      = tbl[i].src;
            pc_target   = tbl[i].tgt;
            chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
                chk($sformatf("row%0d_pc4", i), pc_plus4, tbl[i].e_pc + 32'd4);
            end
            chk($sformatf("row%0d_instret", i), instret, tbl[i].e_cnt);
            tick();
        end

        // Reset while a read is outstanding: the late data must not be captured
        idle_inputs();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        reset       = 1'b1;
        tick();
        check_reset_state("midwait");
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        chk("midwait_req_after", 32'(imem_req), 32'd1);
        chk("midwait_addr_after", imem_addr, 32'h0);

        // PC wrap through the top of the address space
        do_fetch("w0", 32'h0000_0093, 32'h0);
        retire(1'b1, 32'hFFFF_FFFC);
        do_fetch("w1", 32'h0000_0113, 32'hFFFF_FFFC);
        retire(1'b0, 32'h0);
        do_fetch("w2", 32'h0000_0193, 32'h0);
        chk("wrap_instret", instret, 32'd2);

`ifdef FETCH_MISALIGN_TRAP_EN
        retire(1'b1, 32'h42);
        chk("halt_flag", 32'(fetch_misaligned), 32'd1);
        chk("halt_instret", instret, 32'd3);
        imem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("halt_req%0d", k), 32'(imem_req), 32'd0);
            chk($sformatf("halt_valid%0d", k), 32'(instr_valid), 32'd0);
            tick();
        end
        imem_gnt = 1'b0;
`else
        retire(1'b1, 32'h42);
        do_fetch("mask", 32'h0000_0213, 32'h40);
        chk("mask_instret", instret, 32'd3);
`endif

        // Randomized run against a transaction-level model of the fetch stream
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_have  = 1'b0;
        busy    = 1'b0;
        rv_wait = 0;
        retires = 0;
        m_fetch = 32'h0;
        m_instr = NOP;
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        busy_addr = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("rnd_valid", 32'(instr_valid), 32'(m_have));
            chk("rnd_instr", instr, m_have ? m_instr : NOP);
            if (m_have) begin
                chk("rnd_pc", pc, m_pc);
                chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
            end
            chk("rnd_instret", instret, m_cnt);
            if (m_have || busy) chk("rnd_req_idle", 32'(imem_req), 32'd0);
            if (imem_req) chk("rnd_addr", imem_addr, m_fetch);

            imem_gnt    = imem_req && ($urandom_range(0, 3) != 0);
            real_rv     = busy && (rv_wait == 0);
            imem_rvalid = real_rv || (!busy && ($urandom_range(0, 5) == 0));
            imem_rdata  = real_rv ? memw(busy_addr) : $urandom;
            instr_ready = ($urandom_range(0, 2) != 0);
            pc_src      = ($urandom_range(0, 2) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_target   = $urandom & 32'hFFFF_FFFC;
`else
            pc_target   = $urandom;
`endif

            if (m_have && instr_ready) begin
                m_cnt   = m_cnt + 32'd1;
                m_fetch = pc_src ? {pc_target[31:2], 2'b00} : m_pc + 32'd4;
                m_have  = 1'b0;
                retires++;
            end
            if (real_rv) begin
                m_have  = 1'b1;
                m_instr = imem_rdata;
                m_pc    = busy_addr;
                busy    = 1'b0;
            end else if (busy) begin
                rv_wait--;
            end
            if (imem_gnt) begin
                busy      = 1'b1;
                busy_addr = m_fetch;
                rv_wait   = $urandom_range(0, 2);
            end
            tick();
        end
        tests++;
        if (retires < 300) begin
            failures++;
            $display("FAIL rnd_progress: got %0d retires expected at least 300", retires);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the decode/control logic.
- Holds the PC and fetches one 32-bit instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Presents the instruction with its PC to decode over a valid/ready handshake.
- Takes the control unit's pc_src and the externally computed branch/jump target to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded by reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, value held on instr while no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, held until granted.
- imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instr/pc/pc_plus4 valid for decode.
- instr  output  32  fetched instruction; op=instr[6:0], funct3=instr[14:12], funct7_5=instr[30].
- pc  output  32  address of instr.
- pc_plus4  output  32  pc + 4 (mod 2^32), used as jal link value.
- instr_ready  input  1  decode/execute consumes instr this cycle (instruction retires).
- pc_src  input  1  take pc_target as next PC; sampled only on retire.
- pc_target  input  32  branch/jal target (pc + imm).
- instret  output  32  count of retired instructions.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state=S_REQ, fetch PC=RESET_PC, pc=RESET_PC, pc_plus4=RESET_PC+4.
  - instr=NOP_INSTR, instr_valid=0, instret=0.
  - imem_req=0 during the reset cycle.
  - Any outstanding memory transaction is abandoned; instruction memory shares the same reset.
- FSM states S_REQ, S_WAIT, S_VALID; exactly one transaction outstanding at a time.
- S_REQ:
  - imem_req=1, imem_addr=fetch PC, instr_valid=0.
  - imem_gnt=1 -> S_WAIT; otherwise hold with imem_addr stable.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> register instr=imem_rdata, pc=fetch PC, pc_plus4=fetch PC+4, then go to S_VALID.
  - rvalid in the same cycle as gnt is not accepted; data arrives at the earliest one cycle after gnt.
- S_VALID:
  - instr_valid=1; instr/pc/pc_plus4 stable until consumed.
  - instr_ready=1 (retire): fetch PC = pc_src ? pc_target : pc_plus4; instret+=1 (wraps 2^32-1 -> 0); go to S_REQ.
  - instr_ready=0: hold.
- imem_rvalid outside S_WAIT is ignored. instr_ready, pc_src and pc_target are ignored outside S_VALID.
- Minimum throughput: one instruction per 3 cycles with a zero-wait memory (REQ, WAIT, VALID).
- Latency: gnt in cycle N, rvalid in N+1 -> instr_valid=1 in N+2.
- Address arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC gives pc_plus4=0.
- pc_target[1:0] is forced to 2'b00 when loaded unless the optional feature is enabled.
- instr_valid is registered. imem_req and imem_addr are decoded from state and fetch PC only, with no combinational path from any input.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - On retire with pc_src=1 and pc_target[1:0]!=0, fetch_misaligned is set, fetch PC is unchanged, and the FSM enters a terminal S_HALT (imem_req=0, instr_valid=0).
  - Only reset exits S_HALT.
- Undefined: no port and no S_HALT state; target low bits are forced to zero as above.

Test Plan:
- Reset release, memory grants every cycle and returns rdata=32'h0050_0093 one cycle later -> imem_addr=0 on cycle 1; instr_valid=1 on cycle 3 with instr=32'h0050_0093, pc=0, pc_plus4=4.
- Straight-line: 4 instructions, instr_ready held 1, pc_src=0 -> imem_addr sequence 0,4,8,C; instret=4; each instruction valid exactly one cycle.
- Backpressure: instr_ready=0 for 5 cycles in S_VALID -> instr/pc stable, imem_req=0 throughout, instret unchanged; single retire on release.
- Taken branch: retire at pc=8 with pc_src=1, pc_target=32'h40 -> next imem_addr=32'h40; pc_src=1 while instr_ready=0 has no effect.
- Wait states and stray data: gnt delayed 3 cycles, rvalid delayed 2 cycles; rvalid pulsed during S_VALID -> imem_addr held while waiting; stray rvalid ignored; instr unchanged.
- Reset mid-S_WAIT, then pc wrap from 32'hFFFF_FFFC -> restart at RESET_PC with instr_valid=0 and instret=0; wrap gives pc_plus4=0 and next fetch at 0. With FETCH_MISALIGN_TRAP_EN, pc_target=32'h42 -> fetch_misaligned=1 and imem_req stays 0.
